// File: rtl/spi_mmio_pkg.sv
// Shared register offsets, bit positions and FSM encoding for the SPI MMIO master.
package spi_mmio_pkg;

  localparam logic [31:0] SPI_DATA_OFS  = 32'h0;
  localparam logic [31:0] SPI_CTRL_OFS  = 32'h4;

  localparam int SPI_RDY_BIT   = 0;
  localparam int SPI_BUSY_BIT  = 1;
  localparam int SPI_START_BIT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_master_core.sv
// SPI mode-0 byte engine: half-period divider, edge counter and TX/RX shifters.
module spi_master_core
  import spi_mmio_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       busy,
  input  logic       miso,
  output logic       mosi,
  output logic       ss,
  output logic       sck
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  spi_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic          sck_q, sck_d;
  logic          ss_q, ss_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      ss_q    <= 1'b1;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      ss_q    <= ss_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
    end
  end

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    ss_d    = ss_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    done    = 1'b0;

    if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (start) begin
          state_d = SETUP;
          ss_d    = 1'b0;
          tx_sh_d = tx_byte;
          rx_sh_d = '0;
        end
      end
      SETUP: begin
        // leaving SETUP is the first sck rise
        if (tick) begin
          state_d = XFER;
          sck_d   = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], miso};
        end
      end
      XFER: begin
        if (tick) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd15) begin
            state_d = HOLD;
            sck_d   = 1'b0;
          end else if (sck_q) begin
            sck_d   = 1'b0;
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end else begin
            sck_d   = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], miso};
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          ss_d    = 1'b1;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign rx_byte = rx_sh_q;
  assign mosi    = tx_sh_q[7];
  assign ss      = ss_q;
  assign sck     = sck_q;

endmodule

// File: rtl/spi_mmio_master.sv
// Bus-facing SPI master: DATA/CTRL decode, TX/RX holding registers, sticky rdy.
module spi_mmio_master
  import spi_mmio_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  input  logic        miso,
  output logic        mosi,
  output logic        ss,
  output logic        sck
);

  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        rdy_q, rdy_d;
  logic        wr_data, wr_ctrl, start, busy, done;
  logic [7:0]  rx_byte;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{addr[31:3], addr[1:0], wd[31:8]};

  assign wr_data = sel & we & (addr[2] == SPI_DATA_OFS[2]);
  assign wr_ctrl = sel & we & (addr[2] == SPI_CTRL_OFS[2]);
  assign start   = wr_ctrl & wd[SPI_START_BIT] & ~busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_q  <= '0;
      rx_q  <= '0;
      rdy_q <= 1'b0;
    end else begin
      tx_q  <= tx_d;
      rx_q  <= rx_d;
      rdy_q <= rdy_d;
    end
  end

  always_comb begin
    tx_d  = tx_q;
    rx_d  = rx_q;
    rdy_d = rdy_q;
    if (wr_data && !busy) tx_d = wd[7:0];
    if (start) rdy_d = 1'b0;
    // completion lands rx, rdy and busy=0 on the same edge
    if (done) begin
      rx_d  = rx_byte;
      rdy_d = 1'b1;
    end
  end

  always_comb begin
    status               = '0;
    status[SPI_BUSY_BIT] = busy;
    status[SPI_RDY_BIT]  = rdy_q;
    if (!sel)         rd = '0;
    else if (addr[2]) rd = status;
    else              rd = {24'h0, rx_q};
  end

  spi_master_core #(.CLK_DIV(CLK_DIV)) u_core (
    .clk     (clk),
    .rst_n   (rst),
    .start   (start),
    .tx_byte (tx_q),
    .rx_byte (rx_byte),
    .done    (done),
    .busy    (busy),
    .miso    (miso),
    .mosi    (mosi),
    .ss      (ss),
    .sck     (sck)
  );

endmodule

// File: tb/tb_spi_mmio_master.sv
// Scoreboard bench for spi_mmio_master: default divider against a byte slave, plus CLK_DIV=1.
module tb_spi_mmio_master;
  import spi_mmio_pkg::*;

  localparam int D0 = 2;
  localparam int D1 = 1;

  typedef struct {
    logic [7:0] srx;
    logic [7:0] mrx;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0, sel1 = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wd = '0;
  logic [31:0] rd, rd1;
  logic        miso, mosi, ss, sck;
  logic        miso1, mosi1, ss1, sck1;

  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, t_start = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_mmio_master #(.CLK_DIV(D0)) u_dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .miso(miso), .mosi(mosi), .ss(ss), .sck(sck)
  );

  spi_mmio_master #(.CLK_DIV(D1)) u_dut1 (
    .clk(clk), .rst(rst), .sel(sel1), .we(we), .addr(addr), .wd(wd), .rd(rd1),
    .miso(miso1), .mosi(mosi1), .ss(ss1), .sck(sck1)
  );

  assign miso1 = 1'b1;

  // mode-0 slave: reply bit k is valid from rise k until rise k+1
  logic [7:0] s_tx = 8'haa;
  logic [7:0] s_rx = '0;
  int         s_nr = 0;
  assign miso = (s_nr < 8) ? s_tx[7 - s_nr] : 1'b0;

  always @(negedge ss or posedge sck) begin
    if (sck) begin
      if (!ss) begin
        s_rx <= {s_rx[6:0], mosi};
        s_nr <= s_nr + 1;
      end
    end else begin
      s_rx <= '0;
      s_nr <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic bus_wr(input bit u1, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = !u1; sel1 = u1; we = 1'b1; addr = a; wd = d;
    @(posedge clk); #1;
    sel = 1'b0; sel1 = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input bit u1, input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = !u1; sel1 = u1; we = 1'b0; addr = a;
    #1 d = u1 ? rd1 : rd;
    sel = 1'b0; sel1 = 1'b0;
  endtask

  task automatic xfer_start(input bit u1, input bit wr_data, input logic [31:0] txw,
                            input logic [7:0] sb);
    exp_t e;
    if (!u1) s_tx = sb;
    if (wr_data) bus_wr(u1, SPI_DATA_OFS, txw);
    bus_wr(u1, SPI_CTRL_OFS, 32'h4);
    t_start = cyc;
    e.srx = txw[7:0];
    e.mrx = u1 ? 8'hff : sb;
    e.cyc = 18 * (u1 ? D1 : D0);
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input bit u1, output int el, output int hi_max, output bit ok);
    int run;
    run = 0; hi_max = 0; ok = 1'b0;
    @(negedge clk);
    sel = !u1; sel1 = u1; we = 1'b0; addr = SPI_CTRL_OFS;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (u1 ? sck1 : sck) begin
        run++;
        if (run > hi_max) hi_max = run;
      end else run = 0;
      if (!(u1 ? rd1[SPI_BUSY_BIT] : rd[SPI_BUSY_BIT])) begin
        ok = 1'b1;
        break;
      end
    end
    el = cyc - t_start;
    sel = 1'b0; sel1 = 1'b0;
  endtask

  task automatic xfer_check(input bit u1);
    int          el, hm;
    bit          ok;
    logic [31:0] d;
    exp_t        e;
    wait_done(u1, el, hm, ok);
    chk("done_in_budget", 32'(ok), 32'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("xfer_cycles", el, e.cyc);
    chk("sck_high_cycles", hm, u1 ? D1 : D0);
    if (!u1) chk("slave_rx", 32'(s_rx), 32'(e.srx));
    bus_rd(u1, SPI_DATA_OFS, d);
    chk("data_rd", d, {24'h0, e.mrx});
    bus_rd(u1, SPI_CTRL_OFS, d);
    chk("status_done", d, 32'h1);
    chk("ss_idle", 32'(u1 ? ss1 : ss), 32'd1);
    chk("mosi_idle", 32'(u1 ? mosi1 : mosi), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    bit          hit;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ss", 32'(ss), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    bus_rd(0, SPI_CTRL_OFS, d);
    chk("rst_status", d, 32'h0);
    @(negedge clk) rst = 1'b1;
    bus_rd(0, SPI_DATA_OFS, d);
    chk("rst_data", d, 32'h0);

    xfer_start(0, 1'b1, 32'hdeadc0de, 8'haa);
    bus_rd(0, SPI_CTRL_OFS, d);
    chk("status_busy", d, 32'h2);
    xfer_check(0);

    // DATA and CTRL writes mid-transfer must change nothing
    xfer_start(0, 1'b1, 32'h0000003c, 8'h96);
    bus_wr(0, SPI_DATA_OFS, 32'h55);
    bus_wr(0, SPI_CTRL_OFS, 32'h4);
    xfer_check(0);
    xfer_start(0, 1'b0, 32'h0000003c, 8'h0f);
    xfer_check(0);

    xfer_start(0, 1'b1, 32'h000000c3, 8'h77);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (s_nr == 3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("third_rise_seen", 32'(hit), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ss", 32'(ss), 32'd1);
    chk("midrst_sck", 32'(sck), 32'd0);
    sel = 1'b1; addr = SPI_CTRL_OFS;
    #1 chk("midrst_status", rd, 32'h0);
    addr = SPI_DATA_OFS;
    #1 chk("midrst_data", rd, 32'h0);
    sel = 1'b0;
    if (exp_q.size() != 0) exp_q.pop_front();
    @(negedge clk) rst = 1'b1;
    xfer_start(0, 1'b1, 32'h00000081, 8'h5a);
    xfer_check(0);

    xfer_start(1, 1'b1, 32'h000000a5, 8'h00);
    bus_rd(1, SPI_CTRL_OFS, d);
    chk("div1_status_busy", d, 32'h2);
    xfer_check(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
